// File: rtl/adc_spi_if.sv
// adc_spi_if: 4-wire ADC serial link between initiator and responder
interface adc_spi_if;
  logic cs_n;
  logic sclk;
  logic din;
  logic dout;
  modport master (output cs_n, sclk, din, input dout);
  modport slave (input cs_n, sclk, din, output dout);
endinterface

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: ADC-side SPI responder returning the previously addressed channel sample
module adc_spi_responder #(
  parameter int DATA_W = 12,
  parameter int CH_W = 3,
  parameter int FRAME_BITS = 16,
  parameter int ADDR_LSB = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  adc_spi_if.slave                     spi,
  input  logic [DATA_W*(2**CH_W)-1:0]  ch_data,
  output logic [CH_W-1:0]              cur_ch,
  output logic                         frame_done,
  output logic                         frame_err
);
  localparam int CNT_W = $clog2(FRAME_BITS) + 1;
  localparam int RX_W = ADDR_LSB + CH_W - 1;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;
  state_t state_q, state_d;
  logic [2:0] cs_q, cs_d, sclk_q, sclk_d;
  logic [1:0] din_q, din_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [RX_W-1:0] rx_q, rx_d;
  logic [RX_W:0] rx_in;
  logic [CNT_W-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [CH_W-1:0] cur_ch_q, cur_ch_d;
  logic dout_q, dout_d, done_q, done_d, err_q, err_d;
  logic cs_rise, cs_fall, sclk_rise, sclk_fall, last_rise;
  logic [FRAME_BITS-1:0] load_word;
  assign cs_rise = cs_q[1] & ~cs_q[2];
  assign cs_fall = ~cs_q[1] & cs_q[2];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign last_rise = sclk_rise && rise_q == CNT_W'(FRAME_BITS - 1);
  assign rx_in = {rx_q, din_q[1]};
  assign load_word = {{(FRAME_BITS-DATA_W){1'b0}}, ch_data[cur_ch_q*DATA_W +: DATA_W]};
  assign spi.dout = dout_q;
  assign cur_ch = cur_ch_q;
  assign frame_done = done_q;
  assign frame_err = err_q;
  // State register; synchronizers reset to idle pin levels so reset release creates no edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cs_q <= '1;
      sclk_q <= '1;
      din_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      cur_ch_q <= '0;
      dout_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q <= cs_d;
      sclk_q <= sclk_d;
      din_q <= din_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cur_ch_q <= cur_ch_d;
      dout_q <= dout_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  // Frame sequencing; a cs_n edge overrides any sclk edge seen in the same clk
  always_comb begin
    cs_d = {cs_q[1:0], spi.cs_n};
    sclk_d = {sclk_q[1:0], spi.sclk};
    din_d = {din_q[0], spi.din};
    state_d = state_q;
    tx_d = tx_q;
    rx_d = rx_q;
    rise_d = rise_q;
    fall_d = fall_q;
    cur_ch_d = cur_ch_q;
    dout_d = dout_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: begin
        dout_d = 1'b0;
        if (cs_fall) begin
          state_d = SHIFT;
          tx_d = load_word;
          rx_d = '0;
          rise_d = '0;
          fall_d = '0;
          dout_d = load_word[FRAME_BITS-1];
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          dout_d = 1'b0;
          cur_ch_d = last_rise ? rx_in[ADDR_LSB +: CH_W] : cur_ch_q;
          done_d = last_rise;
          err_d = !last_rise;
        end else if (sclk_rise) begin
          rx_d = rx_in[RX_W-1:0];
          rise_d = rise_q + CNT_W'(1);
          if (last_rise) begin
            cur_ch_d = rx_in[ADDR_LSB +: CH_W];
            done_d = 1'b1;
            state_d = WAIT_CS;
          end
        end else if (sclk_fall) begin
          fall_d = (fall_q == CNT_W'(FRAME_BITS)) ? fall_q : fall_q + CNT_W'(1);
          if (fall_q != '0 && fall_q < CNT_W'(FRAME_BITS)) begin
            tx_d = tx_q << 1;
            dout_d = tx_q[FRAME_BITS-2];
          end
        end
      end
      WAIT_CS: begin
        if (cs_rise) begin
          state_d = IDLE;
          dout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: randomized frame-level check of the ADC SPI responder against a channel/bit model
module tb_adc_spi_responder;
  localparam int DW = 12;
  localparam int FB = 16;
  logic clk = 1'b0;
  logic rst;
  logic [DW*8-1:0] ch_data;
  logic [2:0] cur_ch;
  logic frame_done, frame_err;
  logic [2:0] model_ch = 3'd0;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  adc_spi_if spi();
  adc_spi_responder dut (
    .clk(clk),
    .rst(rst),
    .spi(spi),
    .ch_data(ch_data),
    .cur_ch(cur_ch),
    .frame_done(frame_done),
    .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  // Count pulse-clks; a pulse wider than one clk shows up as an extra count
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [11:0] chan(input logic [2:0] k);
    return ch_data[k*DW +: DW];
  endfunction
  // One cs_n-low window with nr sclk cycles; dout is read just before each rising sclk
  task automatic run_frame(input logic [15:0] w, input int nr, input bit together);
    logic [15:0] exp_word;
    int d0, e0;
    bit complete;
    exp_word = {4'h0, chan(model_ch)};
    d0 = done_cnt;
    e0 = err_cnt;
    spi.cs_n = 1'b0;
    clks(8);
    for (int i = 1; i <= nr; i++) begin
      spi.sclk = 1'b0;
      spi.din = (i <= FB) ? w[FB-i] : 1'($urandom);
      clks(8);
      check("dout_bit", {31'd0, spi.dout}, (i <= FB) ? {31'd0, exp_word[FB-i]} : {31'd0, exp_word[0]});
      spi.sclk = 1'b1;
      if (together && i == nr) spi.cs_n = 1'b1;
      if (i == 1) ch_data = {$urandom, $urandom, $urandom};
      clks(8);
    end
    spi.cs_n = 1'b1;
    clks(8);
    complete = nr >= FB;
    if (complete) model_ch = w[13:11];
    check("frame_done_cnt", done_cnt - d0, {31'd0, complete});
    check("frame_err_cnt", err_cnt - e0, {31'd0, !complete});
    check("cur_ch", {29'd0, cur_ch}, {29'd0, model_ch});
    check("dout_idle", {31'd0, spi.dout}, 32'd0);
  endtask
  initial begin
    int d0;
    rst = 1'b1;
    spi.cs_n = 1'b1;
    spi.sclk = 1'b1;
    spi.din = 1'b0;
    ch_data = '0;
    clks(3);
    check("rst_dout", {31'd0, spi.dout}, 32'd0);
    check("rst_cur_ch", {29'd0, cur_ch}, 32'd0);
    check("rst_pulses", done_cnt + err_cnt, 32'd0);
    rst = 1'b0;
    clks(4);
    ch_data = {$urandom, $urandom, $urandom};
    ch_data[0 +: DW] = 12'hABC;
    run_frame(16'h1800, 16, 1'b0);
    check("f1_cur_ch", {29'd0, cur_ch}, 32'd3);
    ch_data[3*DW +: DW] = 12'h5A5;
    run_frame(16'h0000, 16, 1'b0);
    check("f2_cur_ch", {29'd0, cur_ch}, 32'd0);
    run_frame(16'h3800, 7, 1'b0);
    run_frame(16'($urandom), 16, 1'b0);
    run_frame(16'h2800, 20, 1'b0);
    check("overrun_cur_ch", {29'd0, cur_ch}, 32'd5);
    ch_data[5*DW +: DW] = 12'hFFF;
    d0 = done_cnt + err_cnt;
    spi.cs_n = 1'b0;
    clks(8);
    for (int i = 1; i <= 9; i++) begin
      spi.sclk = 1'b0;
      spi.din = 1'($urandom);
      clks(8);
      spi.sclk = 1'b1;
      clks(8);
    end
    check("pre_rst_dout", {31'd0, spi.dout}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_dout", {31'd0, spi.dout}, 32'd0);
    check("midrst_cur_ch", {29'd0, cur_ch}, 32'd0);
    spi.cs_n = 1'b1;
    spi.sclk = 1'b1;
    clks(3);
    rst = 1'b0;
    model_ch = 3'd0;
    clks(6);
    check("midrst_no_pulse", done_cnt + err_cnt - d0, 32'd0);
    run_frame(16'($urandom), 16, 1'b0);
    run_frame(16'h3000, 16, 1'b1);
    run_frame(16'h1800, 10, 1'b1);
    for (int f = 0; f < 25; f++) begin
      int nr;
      nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16 + int'($urandom_range(0, 4));
      run_frame(16'($urandom), nr, 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
